uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NUM_REQ byte producers (command echo, status, debug).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// byte width and a constant-foldable ceil(log2) helper.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_LAUNCH,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE
  } arb_state_e;

  // ceil(log2(value)); usable in parameter defaults
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first valid requester after last_grant, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Walk the search order backwards so the nearest candidate is written last
  always_comb begin
    int cand;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (req_valid[cand[IDX_W-1:0]]) begin
        idx = cand[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. Round-robin
// grants, bursts of up to BURST bytes per grant, start/busy handshake with a
// sticky timeout flag when the transmitter never acknowledges a launch.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BURST    = 4,
  parameter int START_TO = 64,
  parameter int IDX_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      byte_done,
  output logic                      tx_timeout
);

  localparam int CNT_W = clog2(BURST + 1);
  localparam int TO_W  = clog2(START_TO + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                tx_start_q, tx_start_d;
  logic                byte_done_q, byte_done_d;
  logic                tx_timeout_q, tx_timeout_d;

  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  // Unpack the flat data bus into one byte per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Next-state, counters and registered outputs
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    burst_cnt_d  = burst_cnt_q;
    to_cnt_d     = to_cnt_q;
    tx_data_d    = tx_data_q;
    tx_timeout_d = tx_timeout_q;
    req_ready_d  = '0;
    tx_start_d   = 1'b0;
    byte_done_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req_valid && !tx_busy) state_d = ARB_GRANT;
      end
      ARB_GRANT: begin
        // A request withdrawn since IDLE leaves nothing to pick
        if (pick_any) begin
          req_ready_d[pick_idx] = 1'b1;
          tx_data_d    = data_arr[pick_idx];
          grant_idx_d  = pick_idx;
          last_grant_d = pick_idx;
          burst_cnt_d  = CNT_W'(1);
          state_d      = ARB_LAUNCH;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LAUNCH: begin
        tx_start_d = 1'b1;
        to_cnt_d   = '0;
        state_d    = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        // The launched byte is dropped if the transmitter never answers
        if (tx_busy) begin
          state_d = ARB_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(START_TO - 1)) begin
          tx_timeout_d = 1'b1;
          state_d      = ARB_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ARB_WAIT_DONE: begin
        // Busy was high on entry, so the first low sample is the falling edge
        if (!tx_busy) begin
          byte_done_d = 1'b1;
          if (req_valid[grant_idx_q] && (burst_cnt_q < CNT_W'(BURST))) begin
            req_ready_d[grant_idx_q] = 1'b1;
            tx_data_d   = data_arr[grant_idx_q];
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            state_d     = ARB_LAUNCH;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= LAST_RST;
      grant_idx_q  <= '0;
      burst_cnt_q  <= '0;
      to_cnt_q     <= '0;
      tx_data_q    <= '0;
      req_ready_q  <= '0;
      tx_start_q   <= 1'b0;
      byte_done_q  <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      burst_cnt_q  <= burst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      tx_data_q    <= tx_data_d;
      req_ready_q  <= req_ready_d;
      tx_start_q   <= tx_start_d;
      byte_done_q  <= byte_done_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_idx  = grant_idx_q;
  assign byte_done  = byte_done_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue producers, a transmitter model whose
// busy rises 2 clk after tx_start and lasts 20 clk, a table of grant-order
// vectors and hand-written latency, timeout, reset and glitch sequences.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_busy = 1'b0;
  logic [IW-1:0]    grant_idx;
  logic             byte_done;
  logic             tx_timeout;

  uart_tx_arbiter #(
    .NUM_REQ (NR), .DATA_W (DW), .BURST (4), .START_TO (64)
  ) dut (
    .clk (clk), .reset (reset), .req_valid (req_valid), .req_data (req_data),
    .req_ready (req_ready), .tx_start (tx_start), .tx_data (tx_data),
    .tx_busy (tx_busy), .grant_idx (grant_idx), .byte_done (byte_done),
    .tx_timeout (tx_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // producer state: remaining bytes, bytes sent, data base per requester
  int         cnt  [NR] = '{default: 0};
  int         sent [NR] = '{default: 0};
  logic [7:0] base [NR] = '{default: 8'h00};
  int         load_cnt  [NR];
  logic [7:0] load_base [NR];
  int         load_req = 0;
  int         load_ack = 0;
  logic [NR-1:0] pulse_mask = '0;
  logic       tx_mute = 1'b0;

  int         log_idx[$];
  logic [7:0] log_data[$];
  int done_cnt = 0, start_cnt = 0, ready_cnt = 0;

  for (genvar gi = 0; gi < NR; gi++) begin : g_prod
    assign req_valid[gi] = (cnt[gi] != 0) || pulse_mask[gi];
    assign req_data[gi*DW +: DW] = base[gi] + 8'(sent[gi]);
  end

  // producer queues and output monitor, on the falling edge
  always @(negedge clk) begin
    if (load_req != load_ack) begin
      for (int i = 0; i < NR; i++) begin
        cnt[i]  <= load_cnt[i];
        sent[i] <= 0;
        base[i] <= load_base[i];
      end
      load_ack <= load_req;
    end else begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i] && cnt[i] != 0) begin
          cnt[i]  <= cnt[i] - 1;
          sent[i] <= sent[i] + 1;
        end
    end
    if (tx_start) begin
      log_idx.push_back(int'(grant_idx));
      log_data.push_back(tx_data);
      start_cnt <= start_cnt + 1;
      $display("[TB] tx_start idx=%0d data=%h t=%0t", grant_idx, tx_data, $time);
    end
    if (byte_done) done_cnt <= done_cnt + 1;
    if (|req_ready) ready_cnt <= ready_cnt + 1;
  end

  // transmitter model: busy 2 clk after tx_start, held for 20 clk
  logic pend = 1'b0;
  int   hold = 0;
  always @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0; pend <= 1'b0; hold <= 0;
    end else if (tx_start && !tx_mute) begin
      pend <= 1'b1;
    end else if (pend) begin
      pend <= 1'b0; tx_busy <= 1'b1; hold <= 19;
    end else if (tx_busy) begin
      if (hold == 0) tx_busy <= 1'b0;
      else hold <= hold - 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // load per-requester byte counts (nibble i = requester i); b0 is requester 0's base
  task automatic load(input logic [15:0] cnts, input logic [7:0] b0);
    for (int i = 0; i < NR; i++) begin
      load_cnt[i]  = int'(cnts[i*4 +: 4]);
      load_base[i] = 8'((i + 1) * 16);
    end
    load_base[0] = b0;
    load_req++;
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    load(16'h0000, 8'h10);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(negedge clk); #1;
    end
    check(name, done_cnt >= target, 1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] cnts;
    logic [31:0] order;
    int          n;
  } vec_t;
  vec_t vecs[5];

  task automatic set_vec(input int i, input string nm, input logic [15:0] c,
                         input logic [31:0] o, input int n);
    vecs[i].name = nm; vecs[i].cnts = c; vecs[i].order = o; vecs[i].n = n;
  endtask

  initial begin
    int s0, d0, r0, st0, n, eidx;
    int k_of [NR];
    logic [7:0] edata;

    set_vec(0, "rr_all",      16'h1111, 32'h0000_3210, 4);
    set_vec(1, "burst6",      16'h0060, 32'h0011_1111, 6);
    set_vec(2, "burst_share", 16'h0160, 32'h0112_1111, 7);
    set_vec(3, "pair_gap",    16'h3002, 32'h0003_3300, 5);
    set_vec(4, "wrap",        16'h0015, 32'h0001_0000, 6);

    // reset values
    apply_reset();
    check("rst_ready", req_ready, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_done", byte_done, 0);
    check("rst_timeout", tx_timeout, 0);

    // single byte latency
    d0 = done_cnt;
    load(16'h0001, 8'hA5);
    @(posedge clk); #1;
    check("lat_ready_early", req_ready, 0);
    @(posedge clk); #1;
    check("lat_ready", req_ready, 4'b0001);
    check("lat_start_early", tx_start, 0);
    @(posedge clk); #1;
    check("lat_start", tx_start, 1);
    check("lat_data", tx_data, 8'hA5);
    check("lat_ready_drop", req_ready, 0);
    repeat (40) @(posedge clk);
    #1;
    check("lat_done_once", done_cnt - d0, 1);
    check("lat_data_hold", tx_data, 8'hA5);
    check("lat_grant", grant_idx, 0);

    // grant-order table
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      s0 = log_idx.size();
      d0 = done_cnt;
      load(vecs[v].cnts, 8'h10);
      wait_done(d0 + vecs[v].n, vecs[v].n * 40 + 60, {vecs[v].name, "_wait"});
      repeat (30) @(negedge clk);
      #1;
      check({vecs[v].name, "_starts"}, log_idx.size() - s0, vecs[v].n);
      check({vecs[v].name, "_dones"}, done_cnt - d0, vecs[v].n);
      for (int i = 0; i < NR; i++) k_of[i] = 0;
      for (int k = 0; k < vecs[v].n && (s0 + k) < log_idx.size(); k++) begin
        eidx  = int'(vecs[v].order[k*4 +: 4]);
        edata = 8'((eidx + 1) * 16 + k_of[eidx]);
        k_of[eidx]++;
        check($sformatf("%s_idx%0d", vecs[v].name, k), log_idx[s0 + k], eidx);
        check($sformatf("%s_data%0d", vecs[v].name, k), log_data[s0 + k], edata);
      end
    end

    // start timeout with a silent transmitter
    apply_reset();
    tx_mute = 1'b1;
    st0 = start_cnt;
    load(16'h0001, 8'h3C);
    for (int k = 0; k < 100 && start_cnt < st0 + 1; k++) begin
      @(negedge clk); #1;
    end
    check("to_start_seen", start_cnt - st0, 1);
    n = 0;
    while (!tx_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, 64);
    tx_mute = 1'b0;
    d0 = done_cnt;
    load(16'h0010, 8'h10);
    wait_done(d0 + 1, 100, "to_next_served");
    check("to_next_idx", log_idx[log_idx.size() - 1], 1);
    check("to_next_data", log_data[log_data.size() - 1], 8'h20);
    check("to_sticky", tx_timeout, 1);

    // reset in WAIT_DONE with burst_cnt=2
    st0 = start_cnt;
    load(16'h0040, 8'h10);
    for (int k = 0; k < 200 && start_cnt < st0 + 2; k++) begin
      @(negedge clk); #1;
    end
    check("mid_second_start", start_cnt - st0, 2);
    for (int k = 0; k < 10 && !tx_busy; k++) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_grant", grant_idx, 0);
    check("mid_rst_done", byte_done, 0);
    check("mid_rst_timeout", tx_timeout, 0);
    load(16'h0000, 8'h10);
    @(posedge clk); #1 reset = 1'b0;
    s0 = log_idx.size();
    load(16'h0011, 8'h10);
    for (int k = 0; k < 50 && log_idx.size() == s0; k++) begin
      @(negedge clk); #1;
    end
    check("mid_first_seen", log_idx.size() - s0, 1);
    if (log_idx.size() > s0) check("mid_first_idx", log_idx[s0], 0);

    // one-cycle valid glitch in IDLE
    apply_reset();
    r0 = ready_cnt;
    st0 = start_cnt;
    @(posedge clk); #1 pulse_mask = 4'b0100;
    @(posedge clk); #1 pulse_mask = 4'b0000;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_no_ready", ready_cnt - r0, 0);
    check("glitch_no_start", start_cnt - st0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
